// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// default bus widths and the supported read-latency window.
package dataMemPkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      ACK    = 2'd3
   } state_t;

   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 32;

   localparam int RL_MIN    = 1;
   localparam int RL_MAX    = 4;
   localparam int CNT_WIDTH = 3;

endpackage

// File: rtl/data_mem_arbiter_rr_picker.sv
// Two-way round-robin picker, purely combinational; on a tie the requester
// that did not win last time is chosen.
module rr_picker (
   input  logic req0,
   input  logic req1,
   input  logic lastGrant,
   output logic grantValid,
   output logic grantId
);

   always_comb begin
      grantValid = req0 | req1;
      grantId    = req1 & (~req0 | ~lastGrant);
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sequencer for a single-port memory; write ack 2 cycles after grant
// request, read ack 2+READ_LATENCY; requesters wait on ack, inputs sampled only at grant.
module data_mem_arbiter
   import dataMemPkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  memWE,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [DATA_WIDTH-1:0] memDataIn,
   input  logic [DATA_WIDTH-1:0] memDataOut,
   output logic                  busy,
   output logic                  lastGrant
);

   // Out-of-range latencies are pinned to the nearest supported value.
   localparam int RL = (READ_LATENCY < RL_MIN) ? RL_MIN :
                       (READ_LATENCY > RL_MAX) ? RL_MAX : READ_LATENCY;

   state_t                 state;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   cap_we;
   logic                   cap_id;
   logic                   grant_vld;
   logic                   grant_id;
   logic                   sel_we;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;

   rr_picker u_picker (
      .req0       (req0),
      .req1       (req1),
      .lastGrant  (lastGrant),
      .grantValid (grant_vld),
      .grantId    (grant_id)
   );

   always_comb begin
      sel_we    = grant_id ? we1    : we0;
      sel_addr  = grant_id ? addr1  : addr0;
      sel_wdata = grant_id ? wdata1 : wdata0;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_we    <= 1'b0;
         cap_id    <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         memWE     <= 1'b0;
         memAddr   <= '0;
         memDataIn <= '0;
         busy      <= 1'b0;
         lastGrant <= 1'b1;
      end else begin
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         memWE <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  // memAddr/memDataIn double as the captured request fields.
                  cap_we    <= sel_we;
                  cap_id    <= grant_id;
                  lastGrant <= grant_id;
                  memWE     <= sel_we;
                  memAddr   <= sel_addr;
                  memDataIn <= sel_wdata;
                  busy      <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cap_we) begin
                  ack0  <= ~cap_id;
                  ack1  <= cap_id;
                  state <= ACK;
               end else begin
                  cnt   <= CNT_WIDTH'(RL);
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_WIDTH'(1);
               if (cnt == CNT_WIDTH'(1)) begin
                  if (cap_id) rdata1 <= memDataOut;
                  else        rdata0 <= memDataOut;
                  ack0  <= ~cap_id;
                  ack1  <= cap_id;
                  state <= ACK;
               end
            end
            ACK: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: READ_LATENCY=1 instance driven by a vector table
// and corner sequences, plus a READ_LATENCY=3 instance for the long-latency read.
module tb_data_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetN;

   logic        req0_a, we0_a, req1_a, we1_a;
   logic [9:0]  addr0_a, addr1_a, maddr_a;
   logic [31:0] wdata0_a, wdata1_a, rdata0_a, rdata1_a, mdi_a, mdo_a;
   logic        ack0_a, ack1_a, memWE_a, busy_a, lg_a;

   logic        req0_b, we0_b, req1_b, we1_b;
   logic [9:0]  addr0_b, addr1_b, maddr_b;
   logic [31:0] wdata0_b, wdata1_b, rdata0_b, rdata1_b, mdi_b, mdo_b;
   logic        ack0_b, ack1_b, memWE_b, busy_b, lg_b;

   data_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1)) dut_a (
      .clk(clk), .resetN(resetN),
      .req0(req0_a), .we0(we0_a), .addr0(addr0_a), .wdata0(wdata0_a), .ack0(ack0_a), .rdata0(rdata0_a),
      .req1(req1_a), .we1(we1_a), .addr1(addr1_a), .wdata1(wdata1_a), .ack1(ack1_a), .rdata1(rdata1_a),
      .memWE(memWE_a), .memAddr(maddr_a), .memDataIn(mdi_a), .memDataOut(mdo_a),
      .busy(busy_a), .lastGrant(lg_a)
   );

   data_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(3)) dut_b (
      .clk(clk), .resetN(resetN),
      .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b), .rdata0(rdata0_b),
      .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b), .rdata1(rdata1_b),
      .memWE(memWE_b), .memAddr(maddr_b), .memDataIn(mdi_b), .memDataOut(mdo_b),
      .busy(busy_b), .lastGrant(lg_b)
   );

   // Memory models: synchronous write, read pipeline of READ_LATENCY stages.
   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];
   logic [31:0] pipe_a;
   logic [31:0] pipe_b [0:2];
   assign mdo_a = pipe_a;
   assign mdo_b = pipe_b[2];

   initial begin
      for (int i = 0; i < 1024; i++) mem_a[i] = 32'hC0DE0000 + 32'(i);
      pipe_a = '0;
      forever begin
         @(posedge clk);
         pipe_a <= mem_a[maddr_a];
         if (memWE_a) mem_a[maddr_a] <= mdi_a;
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem_b[i] = 32'hC0DE0000 + 32'(i);
      for (int i = 0; i < 3; i++) pipe_b[i] = '0;
      forever begin
         @(posedge clk);
         pipe_b[0] <= mem_b[maddr_b];
         pipe_b[1] <= pipe_b[0];
         pipe_b[2] <= pipe_b[1];
         if (memWE_b) mem_b[maddr_b] <= mdi_b;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        id;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [9];

   // One transaction on instance A; request inputs are scrambled right after the grant.
   task automatic txn_a(input logic id, input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
      int          ack_cyc = -1;
      int          we_cnt  = 0;
      logic        other   = 1'b0;
      logic [9:0]  acc_addr = '0;
      logic [31:0] acc_data = '0;
      logic [31:0] rd_ack   = '0;
      if (id) begin req1_a = 1'b1; we1_a = we; addr1_a = addr; wdata1_a = wdata; end
      else    begin req0_a = 1'b1; we0_a = we; addr0_a = addr; wdata0_a = wdata; end
      for (int c = 1; c <= 8 && ack_cyc < 0; c++) begin
         step();
         if (c == 1) begin
            acc_addr = maddr_a;
            acc_data = mdi_a;
            if (id) begin we1_a = ~we; addr1_a = ~addr; wdata1_a = ~wdata; end
            else    begin we0_a = ~we; addr0_a = ~addr; wdata0_a = ~wdata; end
         end
         if (memWE_a) we_cnt++;
         if (id ? ack0_a : ack1_a) other = 1'b1;
         if (id ? ack1_a : ack0_a) begin
            ack_cyc = c;
            rd_ack  = id ? rdata1_a : rdata0_a;
         end
      end
      req0_a = 1'b0;
      req1_a = 1'b0;
      step();
      check({tag, " ack_cycle"}, 32'(ack_cyc), we ? 32'd2 : 32'd3);
      check({tag, " memWE_cycles"}, 32'(we_cnt), we ? 32'd1 : 32'd0);
      check({tag, " memAddr"}, 32'(acc_addr), 32'(addr));
      if (we) check({tag, " memDataIn"}, acc_data, wdata);
      check({tag, " rdata"}, rd_ack, exp_rd);
      check({tag, " other_ack"}, 32'(other), 32'd0);
      check({tag, " lastGrant"}, 32'(lg_a), 32'(id));
      check({tag, " busy_after"}, 32'(busy_a), 32'd0);
   endtask

   // Read on instance B (latency 3): rdata must hold its old value until the ack cycle.
   task automatic rd_b(input logic [9:0] addr, input logic [31:0] exp_rd,
                       input logic [31:0] prev_rd, input string tag);
      int          ack_cyc = -1;
      int          we_cnt  = 0;
      logic [31:0] rd_pre  = '0;
      logic [31:0] rd_ack  = '0;
      req0_b = 1'b1; we0_b = 1'b0; addr0_b = addr;
      for (int c = 1; c <= 10 && ack_cyc < 0; c++) begin
         step();
         if (memWE_b) we_cnt++;
         if (c == 4) rd_pre = rdata0_b;
         if (ack0_b) begin ack_cyc = c; rd_ack = rdata0_b; end
      end
      req0_b = 1'b0;
      step();
      check({tag, " ack_cycle"}, 32'(ack_cyc), 32'd5);
      check({tag, " rdata_before_ack"}, rd_pre, prev_rd);
      check({tag, " rdata"}, rd_ack, exp_rd);
      check({tag, " memWE_cycles"}, 32'(we_cnt), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      int          a0_first, a0_second, a1_cyc;
      logic        lg0_first, lg0_second, lg1, overlap;
      logic [31:0] rd0, rd1;
      logic [5:0]  obs_busy, obs_we, obs_ack1;
      logic [9:0]  addr_2nd;

      vecs[0] = '{1'b0, 1'b1, 10'd5,   32'hDEADBEEF, 32'h00000000};
      vecs[1] = '{1'b0, 1'b0, 10'd5,   32'h00000000, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 10'd3,   32'hCAFEF00D, 32'h00000000};
      vecs[3] = '{1'b1, 1'b0, 10'd3,   32'h00000000, 32'hCAFEF00D};
      vecs[4] = '{1'b0, 1'b1, 10'd3,   32'h11112222, 32'hDEADBEEF};
      vecs[5] = '{1'b1, 1'b0, 10'd9,   32'h00000000, 32'hC0DE0009};
      vecs[6] = '{1'b0, 1'b0, 10'd3,   32'h00000000, 32'h11112222};
      vecs[7] = '{1'b1, 1'b1, 10'h3FF, 32'hFFFFFFFF, 32'hC0DE0009};
      vecs[8] = '{1'b0, 1'b0, 10'h3FF, 32'h00000000, 32'hFFFFFFFF};

      resetN = 1'b0;
      req0_a = 0; we0_a = 0; addr0_a = '0; wdata0_a = '0;
      req1_a = 0; we1_a = 0; addr1_a = '0; wdata1_a = '0;
      req0_b = 0; we0_b = 0; addr0_b = '0; wdata0_b = '0;
      req1_b = 0; we1_b = 0; addr1_b = '0; wdata1_b = '0;
      step();
      step();
      check("reset ack0", 32'(ack0_a), 32'd0);
      check("reset ack1", 32'(ack1_a), 32'd0);
      check("reset rdata0", rdata0_a, 32'd0);
      check("reset rdata1", rdata1_a, 32'd0);
      check("reset memWE", 32'(memWE_a), 32'd0);
      check("reset memAddr", 32'(maddr_a), 32'd0);
      check("reset memDataIn", mdi_a, 32'd0);
      check("reset busy", 32'(busy_a), 32'd0);
      check("reset lastGrant", 32'(lg_a), 32'd1);
      resetN = 1'b1;
      step();

      for (int v = 0; v < 9; v++)
         txn_a(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rd,
               $sformatf("vec%0d", v));

      // Both requesters hold reads after reset: 0, 1, 0 with no overlapping acks.
      resetN = 1'b0;
      step();
      resetN = 1'b1;
      step();
      check("rr reset lastGrant", 32'(lg_a), 32'd1);
      a0_first = -1; a0_second = -1; a1_cyc = -1;
      lg0_first = 0; lg0_second = 1; lg1 = 0; overlap = 0; rd0 = '0; rd1 = '0;
      req0_a = 1; we0_a = 0; addr0_a = 10'd1;
      req1_a = 1; we1_a = 0; addr1_a = 10'd2;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (ack0_a && ack1_a) overlap = 1'b1;
         if (ack0_a && a0_first < 0) begin a0_first = c; lg0_first = lg_a; rd0 = rdata0_a; end
         else if (ack0_a) begin a0_second = c; lg0_second = lg_a; end
         if (ack1_a) begin a1_cyc = c; lg1 = lg_a; rd1 = rdata1_a; end
      end
      req0_a = 0;
      req1_a = 0;
      step();
      check("rr ack0 first cycle", 32'(a0_first), 32'd3);
      check("rr ack1 cycle", 32'(a1_cyc), 32'd7);
      check("rr ack0 second cycle", 32'(a0_second), 32'd11);
      check("rr lastGrant first", 32'(lg0_first), 32'd0);
      check("rr lastGrant second", 32'(lg1), 32'd1);
      check("rr lastGrant third", 32'(lg0_second), 32'd0);
      check("rr rdata0", rd0, 32'hC0DE0001);
      check("rr rdata1", rd1, 32'hC0DE0002);
      check("rr ack overlap", 32'(overlap), 32'd0);
      check("rr idle after", 32'(busy_a), 32'd0);

      // Requester 1 alone, held for two back-to-back writes.
      check("held busy cycle0", 32'(busy_a), 32'd0);
      req1_a = 1; we1_a = 1; addr1_a = 10'd20; wdata1_a = 32'hA1A1A1A1;
      obs_busy = '0; obs_we = '0; obs_ack1 = '0; addr_2nd = '0;
      for (int c = 1; c <= 6; c++) begin
         step();
         obs_busy[c-1] = busy_a;
         obs_we[c-1]   = memWE_a;
         obs_ack1[c-1] = ack1_a;
         if (c == 4) addr_2nd = maddr_a;
         if (c == 2) begin addr1_a = 10'd21; wdata1_a = 32'hB2B2B2B2; end
         if (c == 5) req1_a = 0;
      end
      check("held busy pattern", 32'(obs_busy), 32'h1B);
      check("held memWE pattern", 32'(obs_we), 32'h09);
      check("held ack1 pattern", 32'(obs_ack1), 32'h12);
      check("held second memAddr", 32'(addr_2nd), 32'd21);
      check("held mem[20]", mem_a[20], 32'hA1A1A1A1);
      check("held mem[21]", mem_a[21], 32'hB2B2B2B2);

      // Reset in the middle of a write's ACCESS cycle.
      req1_a = 1; we1_a = 1; addr1_a = 10'd7; wdata1_a = 32'h77777777;
      step();
      check("abort memWE in access", 32'(memWE_a), 32'd1);
      #3;
      resetN = 1'b0;
      #1;
      check("abort memWE drop", 32'(memWE_a), 32'd0);
      check("abort busy drop", 32'(busy_a), 32'd0);
      req1_a = 0;
      overlap = 0;
      step();
      if (ack1_a) overlap = 1'b1;
      step();
      if (ack1_a) overlap = 1'b1;
      resetN = 1'b1;
      step();
      if (ack1_a) overlap = 1'b1;
      check("abort no ack1", 32'(overlap), 32'd0);
      check("abort idle", 32'(busy_a), 32'd0);
      check("abort mem[7] kept", mem_a[7], 32'hC0DE0007);
      txn_a(1'b1, 1'b0, 10'd7, 32'h0, 32'hC0DE0007, "abort read7");

      // READ_LATENCY=3 instance: write, read elsewhere, then read back.
      req0_b = 1; we0_b = 1; addr0_b = 10'd5; wdata0_b = 32'h12345678;
      step();
      check("rl3 memWE", 32'(memWE_b), 32'd1);
      check("rl3 memAddr", 32'(maddr_b), 32'd5);
      check("rl3 memDataIn", mdi_b, 32'h12345678);
      step();
      check("rl3 write ack0", 32'(ack0_b), 32'd1);
      req0_b = 0;
      step();
      rd_b(10'd6, 32'hC0DE0006, 32'h0, "rl3 read6");
      rd_b(10'd5, 32'h12345678, 32'hC0DE0006, "rl3 read5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
